// File: rtl/multi_shift_unit_if.sv
// Request/response bundle between the ALU and the multi-cycle shifter.
// The master side issues a start request and receives the result; the slave side is the shifter.
interface multi_shift_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       alu_fun;
    logic             shift_EN;
    logic             busy;
    logic [WIDTH-1:0] shift_out;
    logic             shift_carry;
    logic             shift_flag;
    logic             shift_err;

    modport master (
        output A, B, alu_fun, shift_EN,
        input  busy, shift_out, shift_carry, shift_flag, shift_err
    );

    modport slave (
        input  A, B, alu_fun, shift_EN,
        output busy, shift_out, shift_carry, shift_flag, shift_err
    );
endinterface

// File: rtl/multi_shift_unit.sv
// Multi-cycle SRL/SLL/SRA/ROR/ROL shifter, STEP bits per clock; flag after ceil(amt/STEP)+1 edges.
// Start is sampled only while idle; requests during busy are dropped, and no output backpressure exists.
module multi_shift_unit #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rest,
    multi_shift_unit_if.slave  sh
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [2:0] MODE_SRL = 3'b000;
    localparam logic [2:0] MODE_SLL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;

    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

    logic [0:0]       state_q,     state_d;
    logic [WIDTH-1:0] work_q,      work_d;
    logic [AMT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       mode_q,      mode_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] out_q,       out_d;
    logic             out_carry_q, out_carry_d;
    logic             flag_q,      flag_d;
    logic             err_q,       err_d;

    logic [AMT_W-1:0] k;
    logic [WIDTH-1:0] step_work;
    logic             step_carry;

    // Only the low AMT_W bits of B carry the shift amount.
    logic unused_b_hi;
    assign unused_b_hi = ^sh.B[WIDTH-1:AMT_W];

    // A k-bit step is built from k single-bit moves; the carry ends up as the last bit moved out.
    always_comb begin
        k          = (cnt_q > STEP_AMT) ? STEP_AMT : cnt_q;
        step_work  = work_q;
        step_carry = carry_q;
        for (int i = 0; i < STEP; i++) begin
            if (AMT_W'(i) < k) begin
                case (mode_q)
                    MODE_SRL: begin
                        step_carry = step_work[0];
                        step_work  = {1'b0, step_work[WIDTH-1:1]};
                    end
                    MODE_SLL: begin
                        step_carry = step_work[WIDTH-1];
                        step_work  = {step_work[WIDTH-2:0], 1'b0};
                    end
                    MODE_SRA: begin
                        step_carry = step_work[0];
                        step_work  = {step_work[WIDTH-1], step_work[WIDTH-1:1]};
                    end
                    MODE_ROR: begin
                        step_carry = step_work[0];
                        step_work  = {step_work[0], step_work[WIDTH-1:1]};
                    end
                    MODE_ROL: begin
                        step_carry = step_work[WIDTH-1];
                        step_work  = {step_work[WIDTH-2:0], step_work[WIDTH-1]};
                    end
                    default: begin
                        step_carry = step_carry;
                        step_work  = step_work;
                    end
                endcase
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        carry_d     = carry_q;
        out_d       = out_q;
        out_carry_d = out_carry_q;
        flag_d      = 1'b0;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (sh.shift_EN) begin
                    state_d = ST_SHIFT;
                    work_d  = sh.A;
                    cnt_d   = sh.B[AMT_W-1:0];
                    mode_d  = sh.alu_fun;
                    carry_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    work_d  = step_work;
                    carry_d = step_carry;
                    cnt_d   = cnt_q - k;
                end else begin
                    out_d       = work_q;
                    out_carry_d = carry_q;
                    err_d       = (mode_q > MODE_ROL);
                    flag_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            mode_q      <= '0;
            carry_q     <= 1'b0;
            out_q       <= '0;
            out_carry_q <= 1'b0;
            flag_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            carry_q     <= carry_d;
            out_q       <= out_d;
            out_carry_q <= out_carry_d;
            flag_q      <= flag_d;
            err_q       <= err_d;
        end
    end

    assign sh.busy        = (state_q == ST_SHIFT);
    assign sh.shift_out   = out_q;
    assign sh.shift_carry = out_carry_q;
    assign sh.shift_flag  = flag_q;
    assign sh.shift_err   = err_q;
endmodule

// File: tb/tb_multi_shift_unit.sv
// Scoreboard bench: a STEP=1 and a STEP=4 shifter driven with hand-computed directed vectors.
module tb_multi_shift_unit;
    logic clk = 1'b0;
    logic rest;
    always #5 clk = ~clk;

    multi_shift_unit_if #(.WIDTH(16)) b1 ();
    multi_shift_unit_if #(.WIDTH(16)) b4 ();

    multi_shift_unit #(.WIDTH(16), .STEP(1)) dut1 (.clk(clk), .rest(rest), .sh(b1));
    multi_shift_unit #(.WIDTH(16), .STEP(4)) dut4 (.clk(clk), .rest(rest), .sh(b4));

    typedef struct {
        logic [15:0] o;
        logic        c;
        logic        e;
        int          t;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int flags1 = 0, flags4 = 0, starts1 = 0, starts4 = 0;
    logic pf1 = 1'b0, pf4 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop and compare whenever a completion pulse appears.
    always @(negedge clk) begin
        if (rest) begin
            pf1 = 1'b0;
        end else begin
            if (b1.shift_flag) begin
                flags1++;
                chk("flag1_not_back_to_back", pf1, 0);
                chk("busy1_low_at_flag", b1.busy, 0);
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flag1: got flag at cycle %0d, expected none", cyc);
                end else begin
                    e1 = q1.pop_front();
                    chk("out1", b1.shift_out, e1.o);
                    chk("carry1", b1.shift_carry, e1.c);
                    chk("err1", b1.shift_err, e1.e);
                    chk("latency1", cyc, e1.t);
                end
            end
            pf1 = b1.shift_flag;
        end
    end

    always @(negedge clk) begin
        if (rest) begin
            pf4 = 1'b0;
        end else begin
            if (b4.shift_flag) begin
                flags4++;
                chk("flag4_not_back_to_back", pf4, 0);
                chk("busy4_low_at_flag", b4.busy, 0);
                if (q4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flag4: got flag at cycle %0d, expected none", cyc);
                end else begin
                    e4 = q4.pop_front();
                    chk("out4", b4.shift_out, e4.o);
                    chk("carry4", b4.shift_carry, e4.c);
                    chk("err4", b4.shift_err, e4.e);
                    chk("latency4", cyc, e4.t);
                end
            end
            pf4 = b4.shift_flag;
        end
    end

    // n = ceil(amt/STEP); the flag is expected n+1 edges after the accepting edge.
    task automatic issue(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] fun, input logic [15:0] eo, input logic ec,
                         input logic ee, input int n, input bit keep, input bit expect_done);
        int waitc = 0;
        @(negedge clk);
        while (((sel == 1) ? b1.busy : b4.busy) && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", waitc);
        end
        if (sel == 1) begin
            b1.A = a; b1.B = b; b1.alu_fun = fun; b1.shift_EN = 1'b1;
        end else begin
            b4.A = a; b4.B = b; b4.alu_fun = fun; b4.shift_EN = 1'b1;
        end
        @(posedge clk);
        #1;
        if (sel == 1) begin
            chk("busy1_after_accept", b1.busy, 1);
            if (expect_done) begin
                q1.push_back('{eo, ec, ee, cyc + n});
                starts1++;
            end
            if (!keep) b1.shift_EN = 1'b0;
        end else begin
            chk("busy4_after_accept", b4.busy, 1);
            if (expect_done) begin
                q4.push_back('{eo, ec, ee, cyc + n});
                starts4++;
            end
            if (!keep) b4.shift_EN = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int waitc;
        rest = 1'b1;
        b1.A = '0; b1.B = '0; b1.alu_fun = '0; b1.shift_EN = 1'b1;
        b4.A = '0; b4.B = '0; b4.alu_fun = '0; b4.shift_EN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy1", b1.busy, 0);
        chk("rst_out1", b1.shift_out, 16'h0000);
        chk("rst_carry1", b1.shift_carry, 0);
        chk("rst_flag1", b1.shift_flag, 0);
        chk("rst_err1", b1.shift_err, 0);
        chk("rst_busy4", b4.busy, 0);
        chk("rst_out4", b4.shift_out, 16'h0000);
        b1.shift_EN = 1'b0;
        rest = 1'b0;

        // Single-step core cases (n is ceil(amt/1)+1 edges to the flag).
        issue(1, 16'h8001, 16'h0001, 3'b000, 16'h4000, 1'b1, 1'b0, 2,  1'b0, 1'b1);
        @(negedge clk);
        chk("busy1_second_cycle", b1.busy, 1);
        issue(1, 16'h8000, 16'h0004, 3'b010, 16'hF800, 1'b0, 1'b0, 5,  1'b0, 1'b1);
        issue(1, 16'h8001, 16'h0001, 3'b100, 16'h0003, 1'b1, 1'b0, 2,  1'b0, 1'b1);
        issue(1, 16'h0001, 16'h000F, 3'b011, 16'h0002, 1'b0, 1'b0, 16, 1'b0, 1'b1);
        issue(1, 16'h1234, 16'h0000, 3'b001, 16'h1234, 1'b0, 1'b0, 1,  1'b0, 1'b1);
        issue(1, 16'hABCD, 16'h0003, 3'b110, 16'hABCD, 1'b0, 1'b1, 4,  1'b0, 1'b1);
        issue(1, 16'h0181, 16'h0008, 3'b001, 16'h8100, 1'b1, 1'b0, 9,  1'b0, 1'b1);
        issue(1, 16'h0003, 16'hFF01, 3'b000, 16'h0001, 1'b1, 1'b0, 2,  1'b0, 1'b1);

        // Four-bit steps.
        issue(4, 16'h8000, 16'h0004, 3'b010, 16'hF800, 1'b0, 1'b0, 2,  1'b0, 1'b1);
        issue(4, 16'hFFFF, 16'h0007, 3'b000, 16'h01FF, 1'b1, 1'b0, 3,  1'b0, 1'b1);
        issue(4, 16'h0800, 16'h0005, 3'b100, 16'h0001, 1'b1, 1'b0, 3,  1'b0, 1'b1);
        issue(4, 16'h0001, 16'h000F, 3'b011, 16'h0002, 1'b0, 1'b0, 5,  1'b0, 1'b1);
        issue(4, 16'h5A5A, 16'h0000, 3'b111, 16'h5A5A, 1'b0, 1'b1, 1,  1'b0, 1'b1);

        // Start held high: each request is taken on the edge closing the previous flag cycle.
        for (int r = 0; r < 3; r++)
            issue(1, 16'h0006, 16'h0002, 3'b000, 16'h0001, 1'b1, 1'b0, 3, 1'b1, 1'b1);
        b1.shift_EN = 1'b0;

        // A start pulse while busy must be dropped.
        issue(1, 16'h0001, 16'h0003, 3'b001, 16'h0008, 1'b0, 1'b0, 4, 1'b0, 1'b1);
        @(negedge clk);
        b1.A = 16'hFFFF; b1.B = 16'h0001; b1.alu_fun = 3'b000; b1.shift_EN = 1'b1;
        @(posedge clk);
        #1;
        b1.shift_EN = 1'b0;

        // Reset in the middle of a long shift aborts it silently.
        issue(1, 16'hFFFF, 16'h000A, 3'b000, 16'h0000, 1'b0, 1'b0, 11, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rest = 1'b1;
        @(posedge clk);
        #1;
        rest = 1'b0;
        @(negedge clk);
        chk("abort_busy1", b1.busy, 0);
        chk("abort_out1", b1.shift_out, 16'h0000);
        chk("abort_flag1", b1.shift_flag, 0);
        repeat (12) @(negedge clk);
        chk("abort_no_late_flag", flags1, starts1);
        issue(1, 16'h8000, 16'h0001, 3'b010, 16'hC000, 1'b0, 1'b0, 2, 1'b0, 1'b1);

        waitc = 0;
        while ((q1.size() != 0 || q4.size() != 0) && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        repeat (4) @(negedge clk);
        chk("drain_q1", q1.size(), 0);
        chk("drain_q4", q4.size(), 0);
        chk("flags_eq_starts1", flags1, starts1);
        chk("flags_eq_starts4", flags4, starts4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
